// File: rtl/sincos_pkg.sv
// Shared sin/cos pipeline definitions: FSM states, float bias, Q-format default.
// Used by the normalizer, CORDIC core and result packer; no timing of its own.
package sincos_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROTATE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } sincos_state_t;

    localparam int IEEE_BIAS         = 127;
    localparam int FRAC_BITS_DEFAULT = 14;

    // Two's-complement negation that maps -32768 to +32767 instead of wrapping.
    function automatic logic signed [15:0] neg_sat(input logic signed [15:0] x);
        return (x == 16'sh8000) ? 16'sh7FFF : -x;
    endfunction

endpackage

// File: rtl/fixed_to_float.sv
// Exact signed Q-format (16-bit) to IEEE 754 single conversion; purely combinational.
// Zero latency, no handshake; zero encodes as +0.
module fixed_to_float
    import sincos_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
    input  logic [15:0] fix_dat,
    output logic [31:0] flt_dat
);

    logic [15:0] mag;
    logic [4:0]  msb;
    logic [38:0] shifted;
    logic [7:0]  expo;

    always_comb begin
        mag = fix_dat[15] ? (~fix_dat + 16'd1) : fix_dat;
        msb = '0;
        for (int i = 0; i < 16; i++) begin
            if (mag[i]) msb = 5'(i);
        end
        // A 16-bit magnitude always fits in the 24-bit significand, so no rounding.
        shifted = {23'd0, mag} << (5'd23 - msb);
        expo    = 8'(IEEE_BIAS + int'(msb) - FRAC_BITS);
        flt_dat = (mag == 16'd0) ? 32'h0000_0000 : {fix_dat[15], expo, shifted[22:0]};
    end

endmodule

// File: rtl/cordic_result_packer.sv
// Undoes CORDIC quadrant reduction on sin/cos and packs both as IEEE singles.
// Latency 3+|flip| cycles; valid_in ignored while busy, done held until recived.
module cordic_result_packer
    import sincos_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic signed [15:0] sin_in,
    input  logic signed [15:0] cos_in,
    input  logic signed [2:0]  flip,
    input  logic               recived,
    output logic               taken,
    output logic [31:0]        sin_out,
    output logic [31:0]        cos_out,
    output logic               done
);

    sincos_state_t      state;
    logic signed [15:0] s_r;
    logic signed [15:0] c_r;
    logic signed [2:0]  flip_r;
    logic [31:0]        sin_f;
    logic [31:0]        cos_f;

    fixed_to_float #(.FRAC_BITS(FRAC_BITS)) u_sin_cvt (
        .fix_dat (s_r),
        .flt_dat (sin_f)
    );

    fixed_to_float #(.FRAC_BITS(FRAC_BITS)) u_cos_cvt (
        .fix_dat (c_r),
        .flt_dat (cos_f)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            taken   <= 1'b0;
            done    <= 1'b0;
            flip_r  <= '0;
            s_r     <= '0;
            c_r     <= '0;
            sin_out <= '0;
            cos_out <= '0;
        end else begin
            taken <= 1'b0;
            // DONE below overrides this clear when both happen on one edge.
            if (recived) done <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        s_r    <= sin_in;
                        c_r    <= cos_in;
                        flip_r <= flip;
                        taken  <= 1'b1;
                        done   <= 1'b0;
                        state  <= ROTATE;
                    end
                end
                ROTATE: begin
                    if (flip_r < 3'sd0) begin
                        s_r    <= c_r;
                        c_r    <= neg_sat(s_r);
                        flip_r <= flip_r + 3'sd1;
                    end else if (flip_r > 3'sd0) begin
                        s_r    <= neg_sat(c_r);
                        c_r    <= s_r;
                        flip_r <= flip_r - 3'sd1;
                    end else begin
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    sin_out <= sin_f;
                    cos_out <= cos_f;
                    state   <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_result_packer.sv
// Directed bench for cordic_result_packer: transaction-level model plus per-cycle compare.
// Literal expectations pin both the model and the key vectors.
module tb_cordic_result_packer;

    localparam int FB = 14;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [15:0] sin_in;
    logic [15:0] cos_in;
    logic [2:0]  flip;
    logic        recived;
    logic        taken;
    logic [31:0] sin_out;
    logic [31:0] cos_out;
    logic        done;

    always #5 clk = ~clk;

    cordic_result_packer #(.FRAC_BITS(FB)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .sin_in   (sin_in),
        .cos_in   (cos_in),
        .flip     (flip),
        .recived  (recived),
        .taken    (taken),
        .sin_out  (sin_out),
        .cos_out  (cos_out),
        .done     (done)
    );

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int neg_clamp(input int v);
        return (v == -32768) ? 32767 : -v;
    endfunction

    // Real-valued reference: go through a double and repack into single format.
    function automatic logic [31:0] to_float(input int x);
        logic [63:0] d;
        int          e;
        if (x == 0) return 32'h0;
        d = $realtobits(real'(x) / real'(1 << FB));
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Original angle = reduced - 90*f: each -90 step maps (s,c) to (-c,s).
    function automatic logic [63:0] model_pair(input int s0, input int c0, input int f);
        int s, c, t;
        s = s0;
        c = c0;
        for (int i = 0; i < iabs(f); i++) begin
            t = s;
            if (f < 0) begin
                s = c;
                c = neg_clamp(t);
            end else begin
                s = neg_clamp(c);
                c = t;
            end
        end
        return {to_float(s), to_float(c)};
    endfunction

    logic        busy;
    int          k;
    int          total_edges;
    logic [63:0] pend;
    logic        exp_taken;
    logic        exp_done;
    logic [31:0] exp_sin;
    logic [31:0] exp_cos;

    always @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            k         <= 0;
            exp_taken <= 1'b0;
            exp_done  <= 1'b0;
            exp_sin   <= '0;
            exp_cos   <= '0;
        end else begin
            exp_taken <= 1'b0;
            if (busy) begin
                k <= k + 1;
                if (k + 1 == total_edges - 1) begin
                    exp_sin <= pend[63:32];
                    exp_cos <= pend[31:0];
                end
                if (k + 1 == total_edges) begin
                    exp_done <= 1'b1;
                    busy     <= 1'b0;
                end else if (recived) begin
                    exp_done <= 1'b0;
                end
            end else if (valid_in) begin
                pend        <= model_pair(int'($signed(sin_in)), int'($signed(cos_in)), int'($signed(flip)));
                total_edges <= 3 + iabs(int'($signed(flip)));
                k           <= 0;
                busy        <= 1'b1;
                exp_taken   <= 1'b1;
                exp_done    <= 1'b0;
            end else if (recived) begin
                exp_done <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_taken", 32'(taken), 32'(exp_taken));
            chk("cyc_done", 32'(done), 32'(exp_done));
            chk("cyc_sin_out", sin_out, exp_sin);
            chk("cyc_cos_out", cos_out, exp_cos);
        end
    end

    task automatic run_vec(input int s, input int c, input int f, input logic [31:0] es,
                           input logic [31:0] ec, input int ee, input string tag);
        int edges;
        edges = 0;
        @(negedge clk);
        sin_in   = 16'(s);
        cos_in   = 16'(c);
        flip     = 3'(f);
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        while (done !== 1'b1 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        chk({tag, "_edges"}, 32'(edges), 32'(ee));
        chk({tag, "_sin"}, sin_out, es);
        chk({tag, "_cos"}, cos_out, ec);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at t=%0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        rst      = 1'b1;
        valid_in = 1'b0;
        recived  = 1'b0;
        sin_in   = '0;
        cos_in   = '0;
        flip     = '0;
        repeat (3) @(negedge clk);
        chk("rst_taken", 32'(taken), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sin", sin_out, 32'h0);
        chk("rst_cos", cos_out, 32'h0);
        chk("model_one", to_float(16384), 32'h3F80_0000);
        chk("model_m2", to_float(-32768), 32'hC000_0000);
        chk("model_half", to_float(11585), 32'h3F35_0400);
        chk("model_zero", to_float(0), 32'h0);
        chk_en = 1'b1;
        rst    = 1'b0;

        run_vec(0, 16384, 0, 32'h0000_0000, 32'h3F80_0000, 3, "f0");
        run_vec(0, 16384, -1, 32'h3F80_0000, 32'h0000_0000, 4, "fm1");
        run_vec(8192, 14189, 2, 32'hBF00_0000, 32'hBF5D_B400, 5, "fp2");
        run_vec(11585, -32768, 0, 32'h3F35_0400, 32'hC000_0000, 3, "neg_full");
        run_vec(8192, 14189, -4, 32'h3F00_0000, 32'h3F5D_B400, 7, "fm4");
        run_vec(0, 16384, 3, 32'h3F80_0000, 32'h0000_0000, 6, "fp3");
        run_vec(-32768, 0, -1, 32'h0000_0000, 32'h3FFF_FE00, 4, "sat");

        // valid_in held high through ROTATE must only be captured once.
        @(negedge clk);
        sin_in   = 16'd0;
        cos_in   = 16'd16384;
        flip     = 3'd3;
        valid_in = 1'b1;
        pulses   = 0;
        repeat (5) begin
            @(negedge clk);
            if (taken) pulses++;
        end
        valid_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("hold_taken_pulses", 32'(pulses), 32'd1);
        chk("hold_done", 32'(done), 32'd1);

        // recived on the DONE edge loses; recived afterwards clears done.
        @(negedge clk);
        sin_in   = 16'd8192;
        cos_in   = 16'd14189;
        flip     = 3'd0;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        recived = 1'b1;
        @(negedge clk);
        chk("ack_coincident_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("ack_clears_done", 32'(done), 32'd0);
        recived = 1'b0;

        // Reset during ROTATE abandons the conversion.
        @(negedge clk);
        sin_in   = 16'd8192;
        cos_in   = 16'd14189;
        flip     = 3'd3;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_taken", 32'(taken), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sin", sin_out, 32'h0);
        chk("midrst_cos", cos_out, 32'h0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst_no_done", 32'(done), 32'd0);
        run_vec(8192, 14189, 3, 32'h3F5D_B400, 32'hBF00_0000, 6, "after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cordic_result_packer.md
CORDIC_RESULT_PACKER -- requirements
Module: cordic_result_packer

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 14, fraction bits of the signed Q-format inputs.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port valid_in  input  1  CORDIC result available.
REQ-005 SHALL have port sin_in  input  16  signed fixed-point sine of the reduced angle (value = sin_in / 2^FRAC_BITS).
REQ-006 SHALL have port cos_in  input  16  signed fixed-point cosine of the reduced angle, same format as sin_in.
REQ-007 SHALL have port flip  input  3  signed quadrant count, where original angle = reduced angle - 90*flip.
REQ-008 SHALL have port recived  input  1  processor acknowledge of the result.
REQ-009 SHALL have port taken  output  1  one-cycle pulse marking the capture of valid_in.
REQ-010 SHALL have port sin_out  output  32  IEEE 754 single-precision sine.
REQ-011 SHALL have port cos_out  output  32  IEEE 754 single-precision cosine.
REQ-012 SHALL have port done  output  1  sin_out/cos_out valid; held until cleared.

Function
REQ-013 SHALL implement FSM states IDLE, ROTATE, CONVERT, DONE.
REQ-014 SHALL, in IDLE with valid_in=1, register sin_in, cos_in and flip, pulse taken for exactly one cycle, clear done, and go to ROTATE.
REQ-015 SHALL ignore valid_in outside IDLE: no capture and no taken pulse.
REQ-016 SHALL, in ROTATE with flip_r<0, apply (s,c) <- (c,-s) and increment flip_r, one step per cycle.
REQ-017 SHALL, in ROTATE with flip_r>0, apply (s,c) <- (-c,s) and decrement flip_r, one step per cycle.
REQ-018 SHALL, in ROTATE with flip_r=0, go to CONVERT; the full flip range -4..3 is handled.
REQ-019 SHALL saturate negation of -32768 to +32767.
REQ-020 SHALL, in CONVERT, register both floats in the same cycle and go to DONE.
REQ-021 SHALL, in DONE, set done=1 and return to IDLE.
REQ-022 SHALL assert done on the 3+|flip| clock edge after the capture edge.
REQ-023 SHALL convert as follows: sign = input bit 15; mag = |x| as 16-bit unsigned; p = index of mag's MSB; exponent = 127 + p - FRAC_BITS; fraction = (mag << (23-p))[22:0].
REQ-024 SHALL produce an exact conversion with no rounding.
REQ-025 SHALL encode x=0 as 32'h00000000 and never produce -0.
REQ-026 SHALL clear done on the edge after recived=1.
REQ-027 SHALL let DONE-state set of done take priority over a simultaneous recived.
REQ-028 SHALL hold sin_out/cos_out stable from the CONVERT edge until the next CONVERT edge.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, force state to IDLE; taken, done and flip_r to 0; sin_out and cos_out to 32'h0; and captured s/c to 0.
REQ-030 SHALL abandon any conversion in progress when rst asserts mid-operation, with no done pulse for it.
REQ-031 SHALL have rst take priority over valid_in and recived.

Structure
REQ-032 SHALL take state encodings, IEEE bias (127), and FRAC_BITS default from the shared sincos package used with the normalizer and CORDIC.
REQ-033 SHALL implement conversion in one combinational sub-module, fixed_to_float (16-bit signed in, 32-bit float out), instantiated twice.

Verification
REQ-034 SHALL cover: sin_in=0, cos_in=16384, flip=0 -> sin_out=32'h00000000, cos_out=32'h3F800000, done 3 edges after capture.
REQ-035 SHALL cover: sin_in=0, cos_in=16384, flip=-1 -> sin_out=32'h3F800000, cos_out=32'h00000000, done 4 edges after capture.
REQ-036 SHALL cover: sin_in=8192, cos_in=14189, flip=+2 -> sin_out=32'hBF000000, done 5 edges after capture.
REQ-037 SHALL cover: sin_in=11585, cos_in=-32768, flip=0 -> sin_out=32'h3F350400, cos_out=32'hC0000000.
REQ-038 SHALL cover: valid_in held high during ROTATE -> exactly one taken pulse; recived while done=1 -> done=0 next edge; recived coincident with DONE -> done=1.
REQ-039 SHALL cover: rst asserted in ROTATE -> all outputs 0 next edge, no done; a following valid_in completes normally.
